// File: rtl/ucsbece154a_nonarch_regs_if.sv
// Bus bundle for the multicycle non-architectural register bank.
// The master is the controller/datapath side and the slave is the register bank.
interface ucsbece154a_nonarch_regs_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 32
);
  // Controller strobes
  logic                 PCWrite_i;
  logic                 IRWrite_i;
  logic                 AdrSrc_i;
  // Datapath inputs
  logic [WIDTH-1:0]     PCNext_i;
  logic [WIDTH-1:0]     ReadData_i;
  logic [WIDTH-1:0]     RD1_i;
  logic [WIDTH-1:0]     RD2_i;
  logic [WIDTH-1:0]     ALUResult_i;
  // Register outputs
  logic [WIDTH-1:0]     Adr_o;
  logic [WIDTH-1:0]     PC_o;
  logic [WIDTH-1:0]     OldPC_o;
  logic [31:0]          Instr_o;
  logic [WIDTH-1:0]     Data_o;
  logic [WIDTH-1:0]     A_o;
  logic [WIDTH-1:0]     B_o;
  logic [WIDTH-1:0]     ALUOut_o;
  // Decoded instruction fields
  logic [6:0]           op_o;
  logic [2:0]           funct3_o;
  logic                 funct7_o;
  logic [4:0]           rs1_o;
  logic [4:0]           rs2_o;
  logic [4:0]           rd_o;
  // Debug
  logic [CNT_WIDTH-1:0] cycle_cnt_o;
  logic [CNT_WIDTH-1:0] fetch_cnt_o;
  logic                 illegal_o;

  modport master (
    output PCWrite_i, IRWrite_i, AdrSrc_i,
    output PCNext_i, ReadData_i, RD1_i, RD2_i, ALUResult_i,
    input  Adr_o, PC_o, OldPC_o, Instr_o, Data_o, A_o, B_o, ALUOut_o,
    input  op_o, funct3_o, funct7_o, rs1_o, rs2_o, rd_o,
    input  cycle_cnt_o, fetch_cnt_o, illegal_o
  );

  modport slave (
    input  PCWrite_i, IRWrite_i, AdrSrc_i,
    input  PCNext_i, ReadData_i, RD1_i, RD2_i, ALUResult_i,
    output Adr_o, PC_o, OldPC_o, Instr_o, Data_o, A_o, B_o, ALUOut_o,
    output op_o, funct3_o, funct7_o, rs1_o, rs2_o, rd_o,
    output cycle_cnt_o, fetch_cnt_o, illegal_o
  );
endinterface

// File: rtl/ucsbece154a_nonarch_regs.sv
// Non-architectural register bank of the multicycle RISC-V datapath.
// Holds PC, OldPC, Instr, Data, A, B and ALUOut, plus debug counters and a sticky illegal-opcode flag.
// The interface instance must use the same WIDTH/CNT_WIDTH as this module. WIDTH must be at least 32.
module ucsbece154a_nonarch_regs #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      CNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,   // active-low, asynchronous
  ucsbece154a_nonarch_regs_if.slave     bus
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_BRANCH = 7'b1100011,
    OP_ITYPE  = 7'b0010011,
    OP_JAL    = 7'b1101111,
    OP_LUI    = 7'b0110111
  } opcode_e;

  function automatic logic is_supported(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH,
      OP_ITYPE, OP_JAL, OP_LUI: ok = 1'b1;
      default:                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [WIDTH-1:0]     pc_q,      pc_d;
  logic [WIDTH-1:0]     oldpc_q,   oldpc_d;
  logic [31:0]          instr_q,   instr_d;
  logic [WIDTH-1:0]     data_q,    data_d;
  logic [WIDTH-1:0]     a_q,       a_d;
  logic [WIDTH-1:0]     b_q,       b_d;
  logic [WIDTH-1:0]     aluout_q,  aluout_d;
  logic [CNT_WIDTH-1:0] cycle_q,   cycle_d;
  logic [CNT_WIDTH-1:0] fetch_q,   fetch_d;
  logic                 illegal_q, illegal_d;

  // Next-state: enabled loads for PC/IR/OldPC, unconditional loads for the staging registers.
  always_comb begin
    pc_d      = pc_q;
    oldpc_d   = oldpc_q;
    instr_d   = instr_q;
    fetch_d   = fetch_q;
    illegal_d = illegal_q;

    if (bus.PCWrite_i) begin
      pc_d = bus.PCNext_i;
    end
    // OldPC captures the PC before any PCWrite on the same edge.
    if (bus.IRWrite_i) begin
      instr_d = bus.ReadData_i[31:0];
      oldpc_d = pc_q;
      fetch_d = fetch_q + CNT_WIDTH'(1);
      if (!is_supported(bus.ReadData_i[6:0])) begin
        illegal_d = 1'b1;
      end
    end

    data_d   = bus.ReadData_i;
    a_d      = bus.RD1_i;
    b_d      = bus.RD2_i;
    aluout_d = bus.ALUResult_i;
    cycle_d  = cycle_q + CNT_WIDTH'(1);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      oldpc_q   <= '0;
      instr_q   <= NOP_INSTR;
      data_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      aluout_q  <= '0;
      cycle_q   <= '0;
      fetch_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      oldpc_q   <= oldpc_d;
      instr_q   <= instr_d;
      data_q    <= data_d;
      a_q       <= a_d;
      b_q       <= b_d;
      aluout_q  <= aluout_d;
      cycle_q   <= cycle_d;
      fetch_q   <= fetch_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.Adr_o       = bus.AdrSrc_i ? aluout_q : pc_q;
  assign bus.PC_o        = pc_q;
  assign bus.OldPC_o     = oldpc_q;
  assign bus.Instr_o     = instr_q;
  assign bus.Data_o      = data_q;
  assign bus.A_o         = a_q;
  assign bus.B_o         = b_q;
  assign bus.ALUOut_o    = aluout_q;
  assign bus.op_o        = instr_q[6:0];
  assign bus.funct3_o    = instr_q[14:12];
  assign bus.funct7_o    = instr_q[30];
  assign bus.rs1_o       = instr_q[19:15];
  assign bus.rs2_o       = instr_q[24:20];
  assign bus.rd_o        = instr_q[11:7];
  assign bus.cycle_cnt_o = cycle_q;
  assign bus.fetch_cnt_o = fetch_q;
  assign bus.illegal_o   = illegal_q;

endmodule

// File: doc/ucsbece154a_nonarch_regs.md
Name: ucsbece154a_nonarch_regs

Overview:
- Non-architectural register bank of the multicycle RISC-V datapath: PC, OldPC, Instr, Data, A, B and ALUOut.
- Sits directly downstream of the multicycle controller and consumes its PCWrite and IRWrite strobes.
- Feeds the decoded instruction fields (op, funct3, funct7) back to the controller.
- Also holds a cycle counter, a fetched-instruction counter and a sticky illegal-opcode flag for debug.

Parameters:
- WIDTH, 32, datapath width.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- CNT_WIDTH, 32, width of both performance counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- PCWrite_i  input  1  load PC from PCNext_i.
- IRWrite_i  input  1  load Instr from ReadData_i; load OldPC from current PC.
- AdrSrc_i  input  1  memory address select: 0 = PC, 1 = ALUOut.
- PCNext_i  input  WIDTH  Result bus value for the next PC.
- ReadData_i  input  WIDTH  unified memory read data.
- RD1_i  input  WIDTH  register-file read port 1.
- RD2_i  input  WIDTH  register-file read port 2.
- ALUResult_i  input  WIDTH  combinational ALU output.
- Adr_o  output  WIDTH  memory address.
- PC_o  output  WIDTH  current PC.
- OldPC_o  output  WIDTH  PC of the instruction held in Instr.
- Instr_o  output  32  instruction register.
- Data_o  output  WIDTH  memory data register.
- A_o  output  WIDTH  registered RD1.
- B_o  output  WIDTH  registered RD2 (also the store write data).
- ALUOut_o  output  WIDTH  registered ALU result.
- op_o  output  7  Instr[6:0].
- funct3_o  output  3  Instr[14:12].
- funct7_o  output  1  Instr[30].
- rs1_o  output  5  Instr[19:15].
- rs2_o  output  5  Instr[24:20].
- rd_o  output  5  Instr[11:7].
- cycle_cnt_o  output  CNT_WIDTH  cycles since reset release.
- fetch_cnt_o  output  CNT_WIDTH  number of IRWrite strobes since reset.
- illegal_o  output  1  sticky flag: an unsupported opcode was fetched.

Behaviour:
- Reset (reset==0, asynchronous, takes effect immediately regardless of clk):
  - PC=RESET_PC.
  - OldPC, Data, A, B, ALUOut = 0.
  - Instr=32'h00000013 (addi x0,x0,0), so op_o=0010011 while in reset.
  - Both counters = 0; illegal_o = 0.
- Deassertion takes effect at the next rising edge; there is no synchronous reset path.
- PC: on posedge, if PCWrite_i then PC<=PCNext_i, else hold.
- Instr and OldPC: on posedge, if IRWrite_i then Instr<=ReadData_i and OldPC<=PC (the pre-update PC value), else hold.
- PCWrite_i and IRWrite_i together (Fetch state): all three registers update on the same edge.
  - OldPC gets the old PC, never PCNext_i.
  - PC gets PCNext_i.
- Data, A, B, ALUOut: load ReadData_i, RD1_i, RD2_i, ALUResult_i on every posedge, no enable; one-cycle latency.
- Adr_o: combinational, AdrSrc_i ? ALUOut : PC; no added latency.
- Field outputs: combinational slices of Instr. They change only on the edge following an IRWrite_i.
- cycle_cnt_o: +1 every posedge out of reset; wraps from all-ones to 0 with no flag.
- fetch_cnt_o: +1 on each posedge with IRWrite_i==1; wraps the same way.
- illegal_o:
  - On an IRWrite_i edge, the opcode check applies to ReadData_i[6:0] (the value being loaded).
  - Supported opcodes: 0000011, 0100011, 0110011, 1100011, 0010011, 1101111, 0110111.
  - Any other opcode sets illegal_o=1 on that edge.
  - illegal_o is cleared only by reset; later legal fetches leave it at 1.
- Reset mid-instruction: all registers return to reset values at once. The next fetch uses RESET_PC.
- X on an enable input while reset is deasserted is a bench error; no behaviour is defined for it.

Test Plan:
1. Reset: hold reset=0 for 3 cycles, release → PC_o=0, Instr_o=00000013, op_o=0010011, both counters 0 after release, cycle_cnt_o=1 after first edge.
2. Fetch: PC=0x100, PCNext_i=0x104, ReadData_i=0x00500093, PCWrite_i=IRWrite_i=1 for one edge → PC_o=0x104, OldPC_o=0x100, Instr_o=0x00500093, rd_o=1, fetch_cnt_o +1, illegal_o=0.
3. Address mux: ALUResult_i=0x2000 for one edge, then AdrSrc_i=1 → Adr_o=0x2000; AdrSrc_i=0 → Adr_o=PC_o with no clock edge needed.
4. Enable hold: PCWrite_i=IRWrite_i=0 for 10 cycles with changing PCNext_i/ReadData_i → PC, OldPC, Instr unchanged; A_o tracks RD1_i one cycle late.
5. Illegal sticky: fetch ReadData_i=0x0000007F → illegal_o=1 after that edge; a following legal fetch of 0x00000013 leaves illegal_o=1; reset clears it.
6. Async reset mid-op: pull reset low between edges during an execute cycle → all outputs at reset values before the next clk edge; force both counters to all-ones in a separate run and clock once → they wrap to 0.
